mu_charge_arbiter: RTL and testbench

Round-robin arbiter that shares the single μ-cost accumulator between several independent charge requesters (partition engines, split/merge units, the instruction executor). Each requester presents a cost with a valid/ready handshake; the arbiter grants one at a time, adds the cost to the global μ total with saturation, and reports the commit. It sits between the requesters and the core's `mu_cost` output, replacing direct accumulator writes.

---
 rtl/mu_charge_arbiter.sv | 116 +++++++++++
 tb/tb_mu_charge_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mu_charge_arbiter.sv
// rtl/mu_charge_arbiter.sv - round-robin arbiter feeding the shared saturating mu-cost accumulator
module mu_charge_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int COST_W  = 8,
   parameter  int MU_W    = 32,
   parameter  int CNT_W   = 16,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*COST_W-1:0] req_cost,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      clear_mu,
   output logic [MU_W-1:0]           mu_total,
   output logic                      commit_valid,
   output logic [ID_W-1:0]           commit_id,
   output logic [CNT_W-1:0]          commit_count,
   output logic                      overflow,
   output logic                      busy
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COMMIT} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr, id_q, win_id, ptr_nxt;
   logic [COST_W-1:0] cost_q, win_cost;
   logic              win_found;
   logic [ID_W:0]     idx;
   logic [MU_W:0]     base, sum;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(NUM_REQ))
            idx = idx - (ID_W+1)'(NUM_REQ);
         if (!win_found && req_valid[idx[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_id    = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      win_cost = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_id == ID_W'(k))
            win_cost = req_cost[k*COST_W +: COST_W];
      end
   end

   assign ptr_nxt = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + 1'b1;

   // A clear coinciding with the update is applied before the add.
   assign base = clear_mu ? '0 : {1'b0, mu_total};
   assign sum  = base + {{(MU_W+1-COST_W){1'b0}}, cost_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (win_found) state_nxt = S_GRANT;
         S_GRANT:  state_nxt = S_COMMIT;
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign req_ready    = (state == S_GRANT) ? (NUM_REQ'(1) << id_q) : '0;
   assign commit_valid = (state == S_COMMIT);
   assign busy         = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr       <= '0;
         id_q         <= '0;
         cost_q       <= '0;
         mu_total     <= '0;
         overflow     <= 1'b0;
         commit_id    <= '0;
         commit_count <= '0;
      end else begin
         if (state == S_IDLE && win_found) begin
            id_q   <= win_id;
            cost_q <= win_cost;
            rr_ptr <= ptr_nxt;
         end
         if (state == S_GRANT) begin
            commit_count <= commit_count + 1'b1;
            commit_id    <= id_q;
            if (sum[MU_W]) begin
               mu_total <= '1;
               overflow <= 1'b1;
            end else begin
               mu_total <= sum[MU_W-1:0];
               if (clear_mu)
                  overflow <= 1'b0;
            end
         end else if (clear_mu) begin
            mu_total <= '0;
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mu_charge_arbiter.sv
// tb/tb_mu_charge_arbiter.sv - randomized and directed bench for mu_charge_arbiter
module tb_mu_charge_arbiter;

   localparam int N  = 4;
   localparam int CW = 24;
   localparam int MW = 32;
   localparam int KW = 4;
   localparam int IW = 2;
   localparam longint unsigned MU_MAX = (64'd1 << MW) - 64'd1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N*CW-1:0] req_cost = '0;
   logic          clear_mu = 1'b0;
   logic [N-1:0]  req_ready;
   logic [MW-1:0] mu_total;
   logic          commit_valid;
   logic [IW-1:0] commit_id;
   logic [KW-1:0] commit_count;
   logic          overflow;
   logic          busy;

   always #5 clk = ~clk;

   mu_charge_arbiter #(.NUM_REQ(N), .COST_W(CW), .MU_W(MW), .CNT_W(KW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_cost(req_cost),
      .req_ready(req_ready), .clear_mu(clear_mu), .mu_total(mu_total),
      .commit_valid(commit_valid), .commit_id(commit_id),
      .commit_count(commit_count), .overflow(overflow), .busy(busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: phase 0 waiting, 1 granted, 2 committed
   int              m_phase, m_id, m_ptr, m_cid, m_cnt;
   longint unsigned m_cost, m_mu;
   bit              m_ovf, m_ack;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_phase = 0; m_id = 0; m_ptr = 0; m_cid = 0; m_cnt = 0;
      m_cost = 0; m_mu = 0; m_ovf = 0; m_ack = 0;
   endtask

   task automatic model_edge();
      longint unsigned s;
      int i;
      bit found;
      m_ack = 0;
      case (m_phase)
         0: begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               i = (m_ptr + k) % N;
               if (!found && req_valid[i]) begin
                  found = 1;
                  m_id  = i;
               end
            end
            if (found) begin
               m_cost  = 64'(req_cost[m_id*CW +: CW]);
               m_ptr   = (m_id + 1) % N;
               m_phase = 1;
            end
            if (clear_mu) begin m_mu = 0; m_ovf = 0; end
         end
         1: begin
            s = (clear_mu ? 64'd0 : m_mu) + m_cost;
            if (s > MU_MAX) begin
               m_mu  = MU_MAX;
               m_ovf = 1;
            end else begin
               m_mu = s;
               if (clear_mu) m_ovf = 0;
            end
            m_cnt   = (m_cnt + 1) % (1 << KW);
            m_cid   = m_id;
            m_ack   = 1;
            m_phase = 2;
         end
         default: begin
            if (clear_mu) begin m_mu = 0; m_ovf = 0; end
            m_phase = 0;
         end
      endcase
   endtask

   task automatic check_outputs();
      check_eq("req_ready", 64'(req_ready), (m_phase == 1) ? (64'd1 << m_id) : 64'd0);
      check_eq("commit_valid", 64'(commit_valid), 64'(m_phase == 2));
      check_eq("busy", 64'(busy), 64'(m_phase != 0));
      check_eq("mu_total", 64'(mu_total), m_mu);
      check_eq("overflow", 64'(overflow), 64'(m_ovf));
      check_eq("commit_count", 64'(commit_count), 64'(m_cnt));
      check_eq("commit_id", 64'(commit_id), 64'(m_cid));
   endtask

   task automatic tick();
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; req_cost = '0; clear_mu = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_outputs();
   endtask

   task automatic charge(input int id, input longint unsigned cost);
      int guard;
      guard = 0;
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_cost[id*CW +: CW] = CW'(cost);
      do begin
         tick();
         guard++;
      end while (!m_ack && guard < 10);
      req_valid = '0;
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] pend;
      int acks, guard, last_c, r;
      int ids[5];
      int exp_ids[5];
      exp_ids = '{0, 1, 2, 3, 0};

      @(negedge clk);
      check_eq("reset_ready", 64'(req_ready), 64'd0);
      check_eq("reset_mu", 64'(mu_total), 64'd0);
      check_eq("reset_busy", 64'(busy), 64'd0);

      // single requester latency
      do_reset();
      req_valid = 4'b0001;
      req_cost[0 +: CW] = 24'd5;
      tick();
      check_eq("single_ready_t1", 64'(req_ready), 64'b0001);
      tick();
      check_eq("single_mu_t2", 64'(mu_total), 64'd5);
      check_eq("single_cv_t2", 64'(commit_valid), 64'd1);
      check_eq("single_id_t2", 64'(commit_id), 64'd0);
      check_eq("single_cnt_t2", 64'(commit_count), 64'd1);
      req_valid = '0;
      tick();
      check_eq("single_idle_t3", 64'(busy), 64'd0);

      // round-robin fairness with all requesters held
      do_reset();
      for (int i = 0; i < N; i++) req_cost[i*CW +: CW] = CW'(i + 1);
      req_valid = 4'b1111;
      acks = 0; guard = 0; last_c = 0;
      while (acks < 5 && guard < 40) begin
         tick();
         guard++;
         if (commit_valid) begin
            if (acks > 0) check_eq("rr_spacing", 64'(guard - last_c), 64'd3);
            ids[acks] = int'(commit_id);
            last_c = guard;
            acks++;
         end
      end
      check_eq("rr_commits", 64'(acks), 64'd5);
      for (int i = 0; i < 5; i++) check_eq("rr_order", 64'(ids[i]), 64'(exp_ids[i]));
      req_valid = '0;
      tick();
      check_eq("rr_mu", 64'(mu_total), 64'd11);

      // saturation, sticky overflow
      do_reset();
      for (int j = 0; j < 256; j++) charge(j % N, 64'hFFFFFF);
      charge(1, 64'hF0);
      check_eq("sat_preload", 64'(mu_total), 64'hFFFFFFF0);
      check_eq("sat_preload_ovf", 64'(overflow), 64'd0);
      charge(2, 64'h20);
      check_eq("sat_mu", 64'(mu_total), 64'hFFFFFFFF);
      check_eq("sat_ovf", 64'(overflow), 64'd1);
      charge(3, 64'd0);
      check_eq("sat_sticky_mu", 64'(mu_total), 64'hFFFFFFFF);
      check_eq("sat_sticky_ovf", 64'(overflow), 64'd1);

      // clear on the same edge as the grant update, then clear alone
      do_reset();
      charge(1, 64'd100);
      check_eq("clr_pre", 64'(mu_total), 64'd100);
      req_valid = 4'b0010;
      req_cost[1*CW +: CW] = 24'd7;
      tick();
      clear_mu = 1'b1;
      tick();
      clear_mu = 1'b0;
      check_eq("clr_collide_mu", 64'(mu_total), 64'd7);
      check_eq("clr_collide_ovf", 64'(overflow), 64'd0);
      req_valid = '0;
      tick();
      clear_mu = 1'b1;
      tick();
      clear_mu = 1'b0;
      check_eq("clr_idle_mu", 64'(mu_total), 64'd0);

      // asynchronous reset while granting requester 2
      do_reset();
      req_valid = 4'b0100;
      req_cost[2*CW +: CW] = 24'd9;
      tick();
      check_eq("rst_pre_ready", 64'(req_ready), 64'b0100);
      req_valid = 4'b1100;
      req_cost[3*CW +: CW] = 24'd3;
      rst = 1'b1;
      #1;
      check_eq("rst_async_ready", 64'(req_ready), 64'd0);
      check_eq("rst_async_busy", 64'(busy), 64'd0);
      check_eq("rst_async_cv", 64'(commit_valid), 64'd0);
      check_eq("rst_async_cnt", 64'(commit_count), 64'd0);
      model_reset();
      @(negedge clk);
      check_outputs();
      rst = 1'b0;
      tick();
      check_eq("rst_regrant", 64'(req_ready), 64'b0100);
      tick();
      req_valid = '0;
      tick();

      // commit counter wrap at 4 bits
      do_reset();
      for (int j = 0; j < 17; j++) charge(j % N, 64'(j));
      check_eq("wrap_count", 64'(commit_count), 64'd1);

      // randomized traffic against the model
      do_reset();
      pend = '0;
      for (int c = 0; c < 900; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(3) == 0) begin
               pend[i] = 1'b1;
               r = int'($urandom_range(7));
               req_cost[i*CW +: CW] = (r == 0) ? 24'd0 :
                                      (r == 1) ? 24'hFFFFFF : CW'($urandom_range(255));
            end
         end
         req_valid = pend;
         clear_mu  = ($urandom_range(15) == 0);
         tick();
         if (m_ack) pend[m_id] = 1'b0;
      end
      clear_mu  = 1'b0;
      req_valid = '0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
